// File: rtl/xbusarb.sv
// Two-master data-bus arbiter: controller (m0) vs. DMA burst engine (m1).
// Define XBUSARB_FAIR_EN to insert a controller slot after FAIR_N consecutive DMA beats.
module xbusarb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int FAIR_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_sel,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [LEN_W-1:0]  m1_len,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_beat,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_busy,
  output logic              m1_done,
  output logic              s_sel,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata
);

  if (FAIR_N < 1 || LEN_W < 1) begin : g_bad_cfg
    $error("xbusarb: FAIR_N and LEN_W must be at least 1");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic               dir;
  logic [ADDR_W-1:0]  cur_addr;
  logic [LEN_W:0]     beats_left;
  logic               busy, done;
  logic               m0_grant, dma_go, fair_slot, last_beat;

`ifdef XBUSARB_FAIR_EN
  localparam int FAIR_W = $clog2(FAIR_N + 1);
  logic [FAIR_W-1:0] fair_cnt;

  always_comb begin
    fair_slot = (state == BURST) && m0_sel && (fair_cnt == FAIR_W'(FAIR_N));
  end

  // Counts DMA beats that a pending controller access has sat through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             fair_cnt <= '0;
    else if (state != BURST || !m0_sel)   fair_cnt <= '0;
    else if (fair_slot)                   fair_cnt <= '0;
    else                                  fair_cnt <= fair_cnt + FAIR_W'(1);
  end
`else
  always_comb begin
    fair_slot = 1'b0;
  end
`endif

  always_comb begin
    state_nxt = state;
    m0_grant  = 1'b0;
    dma_go    = 1'b0;
    last_beat = (beats_left == (LEN_W+1)'(1));
    case (state)
      IDLE: begin
        m0_grant = m0_sel;
        if (m1_req) state_nxt = BURST;
      end
      BURST: begin
        if (fair_slot) begin
          m0_grant = m0_sel;
        end else begin
          dma_go = 1'b1;
          if (last_beat) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    s_sel    = m0_grant | dma_go;
    s_we     = dma_go ? dir      : (m0_grant & m0_we);
    s_addr   = dma_go ? cur_addr : (m0_grant ? m0_addr  : '0);
    s_wdata  = dma_go ? m1_wdata : (m0_grant ? m0_wdata : '0);
    m0_ready = m0_grant;
    m0_rdata = m0_grant ? s_rdata : '0;
    m1_beat  = dma_go;
    m1_rdata = dma_go ? s_rdata : '0;
    m1_busy  = busy;
    m1_done  = done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir        <= 1'b0;
      cur_addr   <= '0;
      beats_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && m1_req) begin
        dir        <= m1_we;
        cur_addr   <= m1_addr;
        // A zero length field encodes the full 2^LEN_W beats.
        beats_left <= (m1_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, m1_len};
        busy       <= 1'b1;
      end
      if (dma_go) begin
        cur_addr   <= cur_addr + ADDR_W'(1);
        beats_left <= beats_left - (LEN_W+1)'(1);
        if (last_beat) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xbusarb.sv
// Self-checking bench for xbusarb: IDLE vector table, directed burst sequences,
// and random traffic against a queue-based model of pending DMA beat addresses.
module tb_xbusarb;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int FN = 4;
`ifdef XBUSARB_FAIR_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic m0_sel, m0_we, m0_ready;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic m1_req, m1_we, m1_beat, m1_busy, m1_done;
  logic [AW-1:0] m1_addr;
  logic [LW-1:0] m1_len;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic s_sel, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;

  always #5 clk = ~clk;

  xbusarb #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .FAIR_N(FN)) dut (
    .clk(clk), .rst(rst),
    .m0_sel(m0_sel), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_len(m1_len),
    .m1_wdata(m1_wdata), .m1_beat(m1_beat), .m1_rdata(m1_rdata),
    .m1_busy(m1_busy), .m1_done(m1_done),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the outstanding burst is just the list of addresses still to be served.
  logic [AW-1:0] pend_q[$];
  logic pend_we;
  logic exp_done;
  int   waited;
  bit   m_busy, m_beat, m_slot;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    pend_q.delete();
    exp_done = 1'b0;
    waited = 0;
  endtask

  task automatic sample();
    bit ctrl;
    @(negedge clk);
    m_busy = pend_q.size() > 0;
    m_slot = m_busy && FAIR_EN && m0_sel && (waited == FN);
    m_beat = m_busy && !m_slot;
    ctrl   = !m_beat && m0_sel;
    chk("s_sel", s_sel, m_beat | ctrl);
    chk("s_we", s_we, m_beat ? pend_we : (ctrl & m0_we));
    chk("s_addr", s_addr, m_beat ? pend_q[0] : (ctrl ? m0_addr : '0));
    chk("s_wdata", s_wdata, m_beat ? m1_wdata : (ctrl ? m0_wdata : '0));
    chk("m0_ready", m0_ready, ctrl);
    chk("m0_rdata", m0_rdata, ctrl ? s_rdata : '0);
    chk("m1_beat", m1_beat, m_beat);
    chk("m1_busy", m1_busy, m_busy);
    chk("m1_done", m1_done, exp_done);
    if (m_beat && !pend_we) chk("m1_rdata", m1_rdata, s_rdata);
  endtask

  task automatic advance();
    int n;
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      exp_done = m_beat && (pend_q.size() == 1);
      if (m_beat) void'(pend_q.pop_front());
      if (m_slot || !m0_sel || pend_q.size() == 0) waited = 0;
      else if (m_beat) waited++;
      if (!m_busy && m1_req) begin
        n = (m1_len == 0) ? (1 << LW) : int'(m1_len);
        for (int i = 0; i < n; i++) pend_q.push_back(AW'(m1_addr + AW'(i)));
        pend_we = m1_we;
      end
    end
    #1;
  endtask

  task automatic start_burst(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] len);
    m1_req = 1'b1; m1_we = we; m1_addr = a; m1_len = len;
  endtask

  typedef struct {
    logic sel, we; logic [AW-1:0] addr; logic [DW-1:0] wdata, rdata;
    logic e_sel, e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_wdata; logic e_ready; logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vt[6];
  int   rdy_beats[$];
  int   beat_cnt;
  bit   got_done;

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h10, 32'h0, 32'hA5, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hA5};
    vt[1] = '{1'b0, 1'b1, 32'hDEAD, 32'h77, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b1, 32'h24, 32'h1234, 32'h9, 1'b1, 1'b1, 32'h24, 32'h1234, 1'b1, 32'h9};
    vt[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hCAFE, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hCAFE, 1'b1, 32'hFFFF_FFFF};
    vt[4] = '{1'b0, 1'b0, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
    vt[5] = '{1'b1, 1'b1, 32'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 32'h0, 32'h8000_0000, 1'b1, 32'h0};

    rst = 1'b0; m0_sel = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_len = '0; m1_wdata = '0; s_rdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    sample();
    chk("rst_busy", m1_busy, 1'b0);
    chk("rst_done", m1_done, 1'b0);
    chk("rst_beat", m1_beat, 1'b0);
    chk("rst_s_sel", s_sel, 1'b0);
    advance();

    // IDLE controller pass-through table
    for (int i = 0; i < 6; i++) begin
      m0_sel = vt[i].sel; m0_we = vt[i].we; m0_addr = vt[i].addr;
      m0_wdata = vt[i].wdata; s_rdata = vt[i].rdata;
      #1;
      chk($sformatf("vec%0d_s_sel", i), s_sel, vt[i].e_sel);
      chk($sformatf("vec%0d_s_we", i), s_we, vt[i].e_we);
      chk($sformatf("vec%0d_s_addr", i), s_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_s_wdata", i), s_wdata, vt[i].e_wdata);
      chk($sformatf("vec%0d_ready", i), m0_ready, vt[i].e_ready);
      chk($sformatf("vec%0d_rdata", i), m0_rdata, vt[i].e_rdata);
    end
    m0_sel = 0; s_rdata = '0;
    sample(); advance();

    // Write burst, 4 beats from 0x100
    start_burst(1'b1, 32'h100, 8'd4);
    sample(); chk("wr_t_beat", m1_beat, 1'b0); advance();
    m1_req = 0;
    for (int i = 0; i < 4; i++) begin
      m1_wdata = DW'(i + 1);
      sample();
      chk("wr_beat", m1_beat, 1'b1);
      chk("wr_addr", s_addr, 32'h100 + i);
      chk("wr_wdata", s_wdata, i + 1);
      chk("wr_we", s_we, 1'b1);
      advance();
    end
    sample(); chk("wr_done", m1_done, 1'b1); chk("wr_busy_low", m1_busy, 1'b0); advance();
    sample(); chk("wr_done_pulse", m1_done, 1'b0); advance();

    // Controller and burst request in the same IDLE cycle
    m0_sel = 1; m0_we = 0; m0_addr = 32'h20; s_rdata = 32'h3C;
    start_burst(1'b0, 32'h200, 8'd2);
    sample(); chk("tie_ready", m0_ready, 1'b1); chk("tie_rdata", m0_rdata, 32'h3C); advance();
    m1_req = 0; m0_sel = 0;
    sample(); chk("tie_beat1", m1_beat, 1'b1); chk("tie_addr1", s_addr, 32'h200); advance();
    sample(); advance();
    sample(); chk("tie_done", m1_done, 1'b1); advance();

    // 256-beat read burst wrapping the address space
    start_burst(1'b0, 32'hFFFF_FFFE, 8'd0);
    sample(); advance();
    m1_req = 0;
    beat_cnt = 0; got_done = 0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      s_rdata = $urandom;
      sample();
      if (m1_beat) begin
        if (beat_cnt == 2) chk("wrap_addr", s_addr, 32'h0);
        beat_cnt++;
      end
      got_done = m1_done;
      advance();
    end
    chk("wrap_done_seen", got_done, 1'b1);
    chk("wrap_beats", beat_cnt, 256);

    // Controller held through a 16-beat burst
    m0_sel = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h99;
    start_burst(1'b1, 32'h300, 8'd16);
    sample(); advance();
    m1_req = 0;
    beat_cnt = 0; got_done = 0; rdy_beats.delete();
    for (int c = 0; c < 40 && !got_done; c++) begin
      sample();
      if (m1_beat) beat_cnt++;
      if (m0_ready) rdy_beats.push_back(beat_cnt);
      got_done = m1_done;
      advance();
    end
    m0_sel = 0;
    chk("fair_done_seen", got_done, 1'b1);
    chk("fair_beats", beat_cnt, 16);
    if (FAIR_EN) begin
      chk("fair_slots", rdy_beats.size(), 4);
      for (int i = 0; i < 4 && i < rdy_beats.size(); i++)
        chk($sformatf("fair_slot%0d", i), rdy_beats[i], 4 * (i + 1));
    end else begin
      chk("nofair_slots", rdy_beats.size(), 1);
      if (rdy_beats.size() > 0) chk("nofair_slot_pos", rdy_beats[0], 16);
    end

    // Reset mid-burst, with a second request ignored while busy
    start_burst(1'b1, 32'h500, 8'd8);
    sample(); advance();
    start_burst(1'b0, 32'h900, 8'd3);
    sample(); chk("ign_addr", s_addr, 32'h500); advance();
    m1_req = 0;
    sample(); chk("ign_addr2", s_addr, 32'h501); advance();
    rst = 1'b0;
    model_clear();
    #1;
    chk("arst_busy", m1_busy, 1'b0);
    chk("arst_beat", m1_beat, 1'b0);
    chk("arst_done", m1_done, 1'b0);
    chk("arst_s_sel", s_sel, 1'b0);
    sample(); advance();
    rst = 1'b1;
    sample(); chk("arst_idle", m1_busy, 1'b0); advance();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      m0_sel = $urandom_range(0, 1); m0_we = $urandom_range(0, 1);
      m0_addr = $urandom; m0_wdata = $urandom;
      m1_req = ($urandom_range(0, 15) == 0);
      m1_we = $urandom_range(0, 1); m1_addr = $urandom;
      m1_len = ($urandom_range(0, 20) == 0) ? 8'd0 : LW'($urandom_range(1, 9));
      m1_wdata = $urandom; s_rdata = $urandom;
      sample(); advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
